// File: rtl/pc_ras_unit.sv
// Program counter with prioritised next-PC selection and a circular
// return-address stack that tracks overflow/underflow and mispredicted returns.
module pc_ras_unit #(
  parameter int          W     = 32,
  parameter int          DEPTH = 4,
  parameter logic [31:0] ENTRY = 32'h28
) (
  input  logic                   clk,
  input  logic                   INT_n,
  input  logic                   stall,
  input  logic                   isbranch,
  input  logic                   zero,
  input  logic                   isjump,
  input  logic                   isjalr,
  input  logic                   is_call,
  input  logic                   is_ret,
  input  logic [W-1:0]           branch,
  input  logic [W-1:0]           jTarget,
  input  logic [W-1:0]           jalrTarget,
  output logic [W-1:0]           PC,
  output logic [W-1:0]           PCp4,
  output logic [W-1:0]           ras_top,
  output logic [$clog2(DEPTH):0] ras_count,
  output logic                   ras_ovf,
  output logic                   ras_udf,
  output logic [15:0]            ret_miss
);

  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [W-1:0]    ENTRY_W = W'(ENTRY);
  localparam logic [CW-1:0]   FULL    = CW'(DEPTH);
  localparam logic [W-1:0]    LSB_CLR = {{(W-1){1'b1}}, 1'b0};

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) sat_inc16 = v;
    else               sat_inc16 = v + 16'd1;
  endfunction

  function automatic logic [W-1:0] align_jalr(input logic [W-1:0] t);
    align_jalr = t & LSB_CLR;
  endfunction

  logic [W-1:0]  pc_r;
  logic [PW-1:0] ptr_r;
  logic [CW-1:0] cnt_r;
  logic          ovf_r;
  logic          udf_r;
  logic [15:0]   miss_r;
  logic [W-1:0]  ras_mem_r [DEPTH];

  logic [W-1:0]  pcp4_s;
  logic [W-1:0]  top_s;
  logic [W-1:0]  jalr_pc_s;
  logic          push_s;
  logic          pop_s;
  logic [W-1:0]  pc_nxt_s;
  logic [PW-1:0] ptr_nxt_s;
  logic [CW-1:0] cnt_nxt_s;
  logic          ovf_nxt_s;
  logic          udf_nxt_s;
  logic [15:0]   miss_nxt_s;
  logic          wr_en_s;
  logic [PW-1:0] wr_idx_s;

  assign pcp4_s    = pc_r + W'(32'd4);
  assign top_s     = (cnt_r != {CW{1'b0}}) ? ras_mem_r[ptr_r] : {W{1'b0}};
  assign jalr_pc_s = align_jalr(jalrTarget);
  assign push_s    = is_call & (isjump | isjalr);
  assign pop_s     = is_ret & isjalr;

  // Next-state selection for PC, stack pointer, counters and sticky flags.
  always_comb begin
    pc_nxt_s   = pc_r;
    ptr_nxt_s  = ptr_r;
    cnt_nxt_s  = cnt_r;
    ovf_nxt_s  = ovf_r;
    udf_nxt_s  = udf_r;
    miss_nxt_s = miss_r;
    wr_en_s    = 1'b0;
    wr_idx_s   = ptr_r;
    if (!stall) begin
      if (isjalr)                pc_nxt_s = jalr_pc_s;
      else if (isjump)           pc_nxt_s = jTarget;
      else if (isbranch && zero) pc_nxt_s = branch;
      else                       pc_nxt_s = pcp4_s;

      if (push_s && pop_s) begin
        wr_en_s  = 1'b1;
        wr_idx_s = ptr_r;
      end else if (push_s) begin
        wr_en_s   = 1'b1;
        wr_idx_s  = ptr_r + PW'(1'b1);
        ptr_nxt_s = ptr_r + PW'(1'b1);
        // When full the pointer still advances, so the oldest slot is reused.
        if (cnt_r == FULL) ovf_nxt_s = 1'b1;
        else               cnt_nxt_s = cnt_r + CW'(1'b1);
      end else if (pop_s) begin
        if (cnt_r != {CW{1'b0}}) begin
          ptr_nxt_s = ptr_r - PW'(1'b1);
          cnt_nxt_s = cnt_r - CW'(1'b1);
        end else begin
          udf_nxt_s = 1'b1;
        end
      end else begin
        wr_en_s = 1'b0;
      end

      if (pop_s && ((cnt_r == {CW{1'b0}}) || (top_s != jalr_pc_s)))
        miss_nxt_s = sat_inc16(miss_r);
      else
        miss_nxt_s = miss_r;
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge INT_n) begin
    if (!INT_n) begin
      pc_r   <= ENTRY_W;
      ptr_r  <= {PW{1'b0}};
      cnt_r  <= {CW{1'b0}};
      ovf_r  <= 1'b0;
      udf_r  <= 1'b0;
      miss_r <= 16'h0000;
    end else begin
      pc_r   <= pc_nxt_s;
      ptr_r  <= ptr_nxt_s;
      cnt_r  <= cnt_nxt_s;
      ovf_r  <= ovf_nxt_s;
      udf_r  <= udf_nxt_s;
      miss_r <= miss_nxt_s;
    end
  end

  // Stack storage; stale contents are hidden by the zero count after reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) ras_mem_r[wr_idx_s] <= pcp4_s;
  end

  assign PC        = pc_r;
  assign PCp4      = pcp4_s;
  assign ras_top   = top_s;
  assign ras_count = cnt_r;
  assign ras_ovf   = ovf_r;
  assign ras_udf   = udf_r;
  assign ret_miss  = miss_r;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Scoreboard bench for pc_ras_unit: directed stimulus queues expected state,
// a separate monitor pops and compares at each sample event.
module tb_pc_ras_unit;

  logic        clk;
  logic        int_n;
  logic        stall, isbranch, zero, isjump, isjalr, is_call, is_ret;
  logic [31:0] branch, jtarget, jalrtarget;
  logic [31:0] pc, pcp4, ras_top;
  logic [2:0]  ras_count;
  logic        ras_ovf, ras_udf;
  logic [15:0] ret_miss;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] top;
    logic [2:0]  cnt;
    logic        ovf;
    logic        udf;
    logic [15:0] miss;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  pc_ras_unit #(.W(32), .DEPTH(4), .ENTRY(32'h28)) dut (
    .clk(clk), .INT_n(int_n), .stall(stall), .isbranch(isbranch), .zero(zero),
    .isjump(isjump), .isjalr(isjalr), .is_call(is_call), .is_ret(is_ret),
    .branch(branch), .jTarget(jtarget), .jalrTarget(jalrtarget),
    .PC(pc), .PCp4(pcp4), .ras_top(ras_top), .ras_count(ras_count),
    .ras_ovf(ras_ovf), .ras_udf(ras_udf), .ret_miss(ret_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s.%s actual=%h expected=%h", tag, fld, act, expv);
  endtask

  // Monitor: drains the scoreboard each time a sample point is signalled.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "pc",    pc,                  e.pc);
        chk(e.name, "pcp4",  pcp4,                e.pc + 32'd4);
        chk(e.name, "top",   ras_top,             e.top);
        chk(e.name, "count", 32'(ras_count),      32'(e.cnt));
        chk(e.name, "ovf",   32'(ras_ovf),        32'(e.ovf));
        chk(e.name, "udf",   32'(ras_udf),        32'(e.udf));
        chk(e.name, "miss",  32'(ret_miss),       32'(e.miss));
      end
    end
  end

  function automatic exp_t mk(input string n, input logic [31:0] p, input logic [2:0] c,
                              input logic [31:0] t, input logic o, input logic u, input logic [15:0] m);
    exp_t e;
    e.name = n; e.pc = p; e.cnt = c; e.top = t; e.ovf = o; e.udf = u; e.miss = m;
    return e;
  endfunction

  task automatic ctl(input logic st, input logic br, input logic z, input logic j, input logic jr,
                     input logic ca, input logic re, input logic [31:0] b, input logic [31:0] jt,
                     input logic [31:0] jrt);
    stall = st; isbranch = br; zero = z; isjump = j; isjalr = jr;
    is_call = ca; is_ret = re; branch = b; jtarget = jt; jalrtarget = jrt;
  endtask

  task automatic idle();
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  // One clock with current inputs; expectation is sampled 2 time units after the edge.
  task automatic cyc(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    -> chk_ev;
    @(negedge clk);
  endtask

  task automatic chk_now(input exp_t e);
    exp_q.push_back(e);
    #1;
    -> chk_ev;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int_n = 1'b0;
    idle();
    @(negedge clk);
    chk_now(mk("reset", 32'h28, 3'd0, 32'h0, 1'b0, 1'b0, 16'd0));
    int_n = 1'b1;

    cyc(mk("seq1", 32'h2C, 3'd0, 32'h0, 1'b0, 1'b0, 16'd0));
    cyc(mk("seq2", 32'h30, 3'd0, 32'h0, 1'b0, 1'b0, 16'd0));
    cyc(mk("seq3", 32'h34, 3'd0, 32'h0, 1'b0, 1'b0, 16'd0));

    ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0);
    cyc(mk("br_not_taken", 32'h38, 3'd0, 32'h0, 1'b0, 1'b0, 16'd0));
    ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h34, 32'h0);
    cyc(mk("jump", 32'h34, 3'd0, 32'h0, 1'b0, 1'b0, 16'd0));
    ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0);
    cyc(mk("br_taken", 32'h10, 3'd0, 32'h0, 1'b0, 1'b0, 16'd0));
    ctl(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h200, 32'h0);
    cyc(mk("jump_over_br", 32'h200, 3'd0, 32'h0, 1'b0, 1'b0, 16'd0));
    ctl(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 32'h500, 32'h41);
    cyc(mk("jalr_prio_mask", 32'h40, 3'd0, 32'h0, 1'b0, 1'b0, 16'd0));

    ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h0);
    cyc(mk("call", 32'h100, 3'd1, 32'h44, 1'b0, 1'b0, 16'd0));
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h45);
    cyc(mk("ret", 32'h44, 3'd0, 32'h0, 1'b0, 1'b0, 16'd0));
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0);
    cyc(mk("unqualified", 32'h48, 3'd0, 32'h0, 1'b0, 1'b0, 16'd0));

    ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    cyc(mk("to_zero", 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 16'd0));
    ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 32'h0);
    cyc(mk("c1", 32'h10, 3'd1, 32'h04, 1'b0, 1'b0, 16'd0));
    jtarget = 32'h20;
    cyc(mk("c2", 32'h20, 3'd2, 32'h14, 1'b0, 1'b0, 16'd0));
    jtarget = 32'h30;
    cyc(mk("c3", 32'h30, 3'd3, 32'h24, 1'b0, 1'b0, 16'd0));
    jtarget = 32'h40;
    cyc(mk("c4", 32'h40, 3'd4, 32'h34, 1'b0, 1'b0, 16'd0));
    jtarget = 32'h50;
    cyc(mk("c5_ovf", 32'h50, 3'd4, 32'h44, 1'b1, 1'b0, 16'd0));

    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h44);
    cyc(mk("r1", 32'h44, 3'd3, 32'h34, 1'b1, 1'b0, 16'd0));
    jalrtarget = 32'h35;
    cyc(mk("r2", 32'h34, 3'd2, 32'h24, 1'b1, 1'b0, 16'd0));
    jalrtarget = 32'h24;
    cyc(mk("r3", 32'h24, 3'd1, 32'h14, 1'b1, 1'b0, 16'd0));
    jalrtarget = 32'h14;
    cyc(mk("r4", 32'h14, 3'd0, 32'h0, 1'b1, 1'b0, 16'd0));
    jalrtarget = 32'h08;
    cyc(mk("r5_udf", 32'h08, 3'd0, 32'h0, 1'b1, 1'b1, 16'd1));

    idle();
    cyc(mk("walk1", 32'h0C, 3'd0, 32'h0, 1'b1, 1'b1, 16'd1));
    cyc(mk("walk2", 32'h10, 3'd0, 32'h0, 1'b1, 1'b1, 16'd1));
    ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h80, 32'h0);
    cyc(mk("call80", 32'h80, 3'd1, 32'h14, 1'b1, 1'b1, 16'd1));
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 32'h14);
    cyc(mk("call_ret", 32'h14, 3'd1, 32'h84, 1'b1, 1'b1, 16'd1));
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h90);
    cyc(mk("mispredict", 32'h90, 3'd0, 32'h0, 1'b1, 1'b1, 16'd2));
    ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hA0, 32'h0);
    cyc(mk("callA0", 32'hA0, 3'd1, 32'h94, 1'b1, 1'b1, 16'd2));

    ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h700, 32'h800, 32'h900);
    cyc(mk("stall1", 32'hA0, 3'd1, 32'h94, 1'b1, 1'b1, 16'd2));
    cyc(mk("stall2", 32'hA0, 3'd1, 32'h94, 1'b1, 1'b1, 16'd2));

    ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'h0);
    #2;
    int_n = 1'b0;
    chk_now(mk("async_rst", 32'h28, 3'd0, 32'h0, 1'b0, 1'b0, 16'd0));
    cyc(mk("rst_hold", 32'h28, 3'd0, 32'h0, 1'b0, 1'b0, 16'd0));
    int_n = 1'b1;
    idle();
    cyc(mk("post_rst", 32'h2C, 3'd0, 32'h0, 1'b0, 1'b0, 16'd0));
    ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h60, 32'h0);
    cyc(mk("post_rst_call", 32'h60, 3'd1, 32'h30, 1'b0, 1'b0, 16'd0));
    idle();

    #5;
    total_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain actual=%0d expected=0", exp_q.size());
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
